// File: rtl/btp_pkg.sv
// Shared types and counter helpers for the branch-target predictor.
// Used by branch_target_predictor and btp_sat_counter.
package btp_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } btp_state_e;

  function automatic logic [31:0] CNT_MAX(input int cntBits);
    return (32'd1 << cntBits) - 32'd1;
  endfunction

  // Weakly taken: MSB set, every lower bit clear.
  function automatic logic [31:0] CNT_WEAK_TAKEN(input int cntBits);
    return 32'd1 << (cntBits - 1);
  endfunction

endpackage

// File: rtl/btp_sat_counter.sv
// Next-state logic for one saturating direction counter.
// Shared by all table entries: only the entry being trained passes through it.
module btp_sat_counter
  import btp_pkg::*;
#(
  parameter int CNT_BITS = 2
) (
  input  logic [CNT_BITS-1:0] i_cnt,
  input  logic                i_inc,
  output logic [CNT_BITS-1:0] o_next
);

  localparam logic [CNT_BITS-1:0] LP_CNT_MAX = CNT_BITS'(CNT_MAX(CNT_BITS));

  always_comb begin
    o_next = i_cnt;
    if (i_inc) begin
      if (i_cnt != LP_CNT_MAX) o_next = i_cnt + 1'b1;
    end else if (i_cnt != '0) begin
      o_next = i_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/branch_target_predictor.sv
// Branch-target predictor: combinational lookup from IF, training from EX,
// valid-bit sweep after reset. Performance counters are built only with BTP_STATS_EN.
module branch_target_predictor
  import btp_pkg::*;
#(
  parameter int WORD_SIZE  = 16,
  parameter int INDEX_BITS = 8,
  parameter int CNT_BITS   = 2
) (
  input  logic                 Clk,
  input  logic                 Reset_N,
  input  logic                 if_valid,
  input  logic [WORD_SIZE-1:0] if_pc,
  output logic [WORD_SIZE-1:0] if_pred_pc,
  output logic                 if_pred_taken,
  input  logic                 ex_branch,
  input  logic                 ex_jump,
  input  logic                 ex_bcond,
  input  logic [WORD_SIZE-1:0] ex_pc,
  input  logic [WORD_SIZE-1:0] ex_target,
  input  logic                 ex_mispredict,
  output logic                 ready,
  output logic [WORD_SIZE-1:0] stat_hits,
  output logic [WORD_SIZE-1:0] stat_updates,
  output logic [WORD_SIZE-1:0] stat_mispredicts
);

  localparam int LP_ENTRIES  = 1 << INDEX_BITS;
  localparam int LP_TAG_BITS = WORD_SIZE - INDEX_BITS;
  localparam logic [CNT_BITS-1:0] LP_CNT_MAX  = CNT_BITS'(CNT_MAX(CNT_BITS));
  localparam logic [CNT_BITS-1:0] LP_CNT_WEAK = CNT_BITS'(CNT_WEAK_TAKEN(CNT_BITS));

  btp_state_e              r_state, w_nextState;
  logic [INDEX_BITS-1:0]   r_sweepIdx, w_nextSweepIdx;
  logic                    w_ready, w_sweepClr;

  logic                    r_valid  [LP_ENTRIES];
  logic [LP_TAG_BITS-1:0]  r_tag    [LP_ENTRIES];
  logic [WORD_SIZE-1:0]    r_target [LP_ENTRIES];
  logic [CNT_BITS-1:0]     r_cnt    [LP_ENTRIES];

  logic [INDEX_BITS-1:0]   w_ifIdx, w_exIdx;
  logic [LP_TAG_BITS-1:0]  w_ifTag, w_exTag;
  logic                    w_ifHit, w_exHit, w_update;
  logic                    w_wrEntry, w_wrCnt;
  logic [CNT_BITS-1:0]     w_cntNext, w_cntWrData;

  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      r_state    <= ST_INIT;
      r_sweepIdx <= '0;
    end else begin
      r_state    <= w_nextState;
      r_sweepIdx <= w_nextSweepIdx;
    end
  end

  always_comb begin
    w_nextState    = r_state;
    w_nextSweepIdx = r_sweepIdx;
    w_ready        = 1'b0;
    w_sweepClr     = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_sweepClr     = 1'b1;
        w_nextSweepIdx = r_sweepIdx + 1'b1;
        if (r_sweepIdx == {INDEX_BITS{1'b1}}) w_nextState = ST_RUN;
      end
      ST_RUN:  w_ready = 1'b1;
      default: w_nextState = ST_INIT;
    endcase
  end

  assign ready   = w_ready;
  assign w_ifIdx = if_pc[INDEX_BITS-1:0];
  assign w_ifTag = if_pc[WORD_SIZE-1:INDEX_BITS];
  assign w_exIdx = ex_pc[INDEX_BITS-1:0];
  assign w_exTag = ex_pc[WORD_SIZE-1:INDEX_BITS];

  assign w_ifHit       = r_valid[w_ifIdx] && (r_tag[w_ifIdx] == w_ifTag);
  assign if_pred_taken = w_ready && w_ifHit && r_cnt[w_ifIdx][CNT_BITS-1];
  assign if_pred_pc    = if_pred_taken ? r_target[w_ifIdx] : if_pc + 1'b1;

  assign w_exHit  = r_valid[w_exIdx] && (r_tag[w_exIdx] == w_exTag);
  assign w_update = w_ready && (ex_branch || ex_jump);

  btp_sat_counter #(.CNT_BITS(CNT_BITS)) u_satCounter (
    .i_cnt  (r_cnt[w_exIdx]),
    .i_inc  (ex_bcond),
    .o_next (w_cntNext)
  );

  always_comb begin
    w_wrEntry   = 1'b0;
    w_wrCnt     = 1'b0;
    w_cntWrData = w_cntNext;
    if (w_update) begin
      if (ex_jump) begin
        w_wrEntry   = 1'b1;
        w_wrCnt     = 1'b1;
        w_cntWrData = LP_CNT_MAX;
      end else if (ex_bcond) begin
        w_wrEntry = 1'b1;
        w_wrCnt   = 1'b1;
        if (!w_exHit) w_cntWrData = LP_CNT_WEAK;
      end else if (w_exHit) begin
        w_wrCnt = 1'b1;
      end
    end
  end

  // Sweep and training never overlap: training is gated by ready.
  always_ff @(posedge Clk) begin
    if (Reset_N) begin
      if (w_sweepClr) begin
        r_valid[r_sweepIdx] <= 1'b0;
      end else if (w_wrEntry) begin
        r_valid[w_exIdx]  <= 1'b1;
        r_tag[w_exIdx]    <= w_exTag;
        r_target[w_exIdx] <= ex_target;
      end
      if (w_wrCnt) r_cnt[w_exIdx] <= w_cntWrData;
    end
  end

`ifdef BTP_STATS_EN
  logic [WORD_SIZE-1:0] r_statHits, r_statUpdates, r_statMispredicts;

  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      r_statHits        <= '0;
      r_statUpdates     <= '0;
      r_statMispredicts <= '0;
    end else begin
      if (if_valid && if_pred_taken && (r_statHits != '1)) r_statHits <= r_statHits + 1'b1;
      if (w_update && (r_statUpdates != '1)) r_statUpdates <= r_statUpdates + 1'b1;
      if (w_ready && ex_mispredict && (r_statMispredicts != '1))
        r_statMispredicts <= r_statMispredicts + 1'b1;
    end
  end

  assign stat_hits        = r_statHits;
  assign stat_updates     = r_statUpdates;
  assign stat_mispredicts = r_statMispredicts;
`else
  logic w_unusedStatInputs;
  assign w_unusedStatInputs = &{1'b0, if_valid, ex_mispredict};
  assign stat_hits          = '0;
  assign stat_updates       = '0;
  assign stat_mispredicts   = '0;
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// Scoreboard bench for branch_target_predictor (INDEX_BITS=4, CNT_BITS=2).
// Stats expectations follow BTP_STATS_EN when the macro is defined.
module tb_branch_target_predictor;

  localparam int WS      = 16;
  localparam int IB      = 4;
  localparam int CB      = 2;
  localparam int ENTRIES = 1 << IB;
  localparam int CMAX    = (1 << CB) - 1;
  localparam int CWEAK   = 1 << (CB - 1);

  logic          Clk = 1'b0;
  logic          Reset_N = 1'b0;
  logic          if_valid = 1'b0;
  logic [WS-1:0] if_pc = '0;
  logic [WS-1:0] if_pred_pc;
  logic          if_pred_taken;
  logic          ex_branch = 1'b0, ex_jump = 1'b0, ex_bcond = 1'b0;
  logic [WS-1:0] ex_pc = '0, ex_target = '0;
  logic          ex_mispredict = 1'b0;
  logic          ready;
  logic [WS-1:0] stat_hits, stat_updates, stat_mispredicts;

  branch_target_predictor #(.WORD_SIZE(WS), .INDEX_BITS(IB), .CNT_BITS(CB)) dut (
    .Clk(Clk), .Reset_N(Reset_N), .if_valid(if_valid), .if_pc(if_pc),
    .if_pred_pc(if_pred_pc), .if_pred_taken(if_pred_taken),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_bcond(ex_bcond),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_mispredict(ex_mispredict),
    .ready(ready), .stat_hits(stat_hits), .stat_updates(stat_updates),
    .stat_mispredicts(stat_mispredicts)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic          rstN, ifValid;
    logic [WS-1:0] ifPc;
    logic          exBranch, exJump, exBcond;
    logic [WS-1:0] exPc, exTarget;
    logic          exMisp;
  } stim_t;

  typedef struct {
    logic [WS-1:0] predPc;
    logic          predTaken, rdy;
    logic [WS-1:0] hits, updates, misp;
  } exp_t;

  exp_t expQ[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: the whole table is forgotten at reset; ready after ENTRIES running cycles.
  bit mKnown = 0;
  int mCount = 0;
  bit mValid [ENTRIES];
  int mTag [ENTRIES];
  int mTarget [ENTRIES];
  int mCnt [ENTRIES];
  int mHits = 0, mUpd = 0, mMisp = 0;

  function automatic bit mReady();
    return mCount >= ENTRIES;
  endfunction

  function automatic bit mHit(input int pc);
    return mValid[pc % ENTRIES] && (mTag[pc % ENTRIES] == pc / ENTRIES);
  endfunction

  task automatic mPredict(input int pc, output bit taken, output int npc);
    int idx = pc % ENTRIES;
    taken = mReady() && mHit(pc) && (mCnt[idx] >= CWEAK);
    npc   = taken ? mTarget[idx] : (pc + 1) % 65536;
  endtask

  function automatic int satInc(input int v, input int maxV);
    return (v < maxV) ? v + 1 : v;
  endfunction

  task automatic mStep(input stim_t s);
    bit taken;
    int npc, idx;
    if (!s.rstN) begin
      mKnown = 1;
      mCount = 0;
      foreach (mValid[i]) mValid[i] = 0;
      mHits = 0; mUpd = 0; mMisp = 0;
    end else if (mKnown) begin
      if (!mReady()) begin
        mCount++;
      end else begin
        mPredict(int'(s.ifPc), taken, npc);
        if (s.ifValid && taken) mHits = satInc(mHits, 65535);
        if (s.exMisp) mMisp = satInc(mMisp, 65535);
        idx = int'(s.exPc) % ENTRIES;
        if (s.exBranch || s.exJump) begin
          mUpd = satInc(mUpd, 65535);
          if (s.exJump || (s.exBcond && !mHit(int'(s.exPc)))) begin
            mValid[idx]  = 1;
            mTag[idx]    = int'(s.exPc) / ENTRIES;
            mTarget[idx] = int'(s.exTarget);
            mCnt[idx]    = s.exJump ? CMAX : CWEAK;
          end else if (s.exBcond) begin
            mTarget[idx] = int'(s.exTarget);
            mCnt[idx]    = satInc(mCnt[idx], CMAX);
          end else if (mHit(int'(s.exPc))) begin
            mCnt[idx] = (mCnt[idx] > 0) ? mCnt[idx] - 1 : 0;
          end
        end
      end
    end
  endtask

  function automatic stim_t mk(input logic rstN, input logic ifValid, input logic [WS-1:0] ifPc,
                               input logic br, input logic jmp, input logic bc,
                               input logic [WS-1:0] exPc, input logic [WS-1:0] tgt, input logic misp);
    stim_t s;
    s.rstN = rstN; s.ifValid = ifValid; s.ifPc = ifPc;
    s.exBranch = br; s.exJump = jmp; s.exBcond = bc;
    s.exPc = exPc; s.exTarget = tgt; s.exMisp = misp;
    return s;
  endfunction

  task automatic applyStimulus(input stim_t s);
    exp_t e;
    bit   taken;
    int   npc;
    Reset_N = s.rstN; if_valid = s.ifValid; if_pc = s.ifPc;
    ex_branch = s.exBranch; ex_jump = s.exJump; ex_bcond = s.exBcond;
    ex_pc = s.exPc; ex_target = s.exTarget; ex_mispredict = s.exMisp;
    if (mKnown) begin
      mPredict(int'(s.ifPc), taken, npc);
      e.predPc    = WS'(npc);
      e.predTaken = taken;
      e.rdy       = mReady();
`ifdef BTP_STATS_EN
      e.hits = WS'(mHits); e.updates = WS'(mUpd); e.misp = WS'(mMisp);
`else
      e.hits = '0; e.updates = '0; e.misp = '0;
`endif
      expQ.push_back(e);
    end
    @(posedge Clk);
    mStep(s);
    #1;
  endtask

  function automatic void cmp(input string name, input logic [WS-1:0] act, input logic [WS-1:0] req);
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
    end
  endfunction

  task automatic checkOutput(input exp_t e);
    vectors++;
    cmp("if_pred_pc", if_pred_pc, e.predPc);
    cmp("if_pred_taken", WS'(if_pred_taken), WS'(e.predTaken));
    cmp("ready", WS'(ready), WS'(e.rdy));
    cmp("stat_hits", stat_hits, e.hits);
    cmp("stat_updates", stat_updates, e.updates);
    cmp("stat_mispredicts", stat_mispredicts, e.misp);
  endtask

  always @(negedge Clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  function automatic logic [WS-1:0] randPc();
    if ($urandom_range(0, 3) == 0) return WS'($urandom);
    return WS'(($urandom_range(0, 2) << IB) | $urandom_range(0, ENTRIES - 1));
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t idle;
    @(posedge Clk); #1;
    applyStimulus(mk(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0));
    applyStimulus(mk(0, 1, 16'h0003, 0, 0, 0, 16'h0000, 16'h0000, 0));
    // Training attempted during the sweep must be dropped.
    for (int i = 0; i < ENTRIES; i++)
      applyStimulus(mk(1, 1, 16'h0003, 1, 1, 1, 16'h0003, 16'h0ABC, 1));
    applyStimulus(mk(1, 1, 16'h0003, 0, 0, 0, 16'h0000, 16'h0000, 0));

    applyStimulus(mk(1, 1, 16'h0010, 0, 1, 0, 16'h0010, 16'h0040, 0));
    applyStimulus(mk(1, 1, 16'h0010, 0, 0, 0, 16'h0000, 16'h0000, 0));

    applyStimulus(mk(1, 1, 16'h0020, 1, 0, 1, 16'h0020, 16'h0077, 0));
    applyStimulus(mk(1, 1, 16'h0020, 1, 0, 1, 16'h0020, 16'h0077, 0));
    applyStimulus(mk(1, 1, 16'h0020, 1, 0, 0, 16'h0020, 16'h0000, 1));
    applyStimulus(mk(1, 1, 16'h0020, 1, 0, 0, 16'h0020, 16'h0000, 0));
    applyStimulus(mk(1, 1, 16'h0020, 1, 0, 0, 16'h0020, 16'h0000, 0));
    applyStimulus(mk(1, 1, 16'h0020, 1, 0, 0, 16'h0020, 16'h0000, 0));
    applyStimulus(mk(1, 1, 16'h0020, 0, 0, 0, 16'h0000, 16'h0000, 0));

    applyStimulus(mk(1, 1, 16'h0105, 1, 0, 1, 16'h0105, 16'h0200, 0));
    applyStimulus(mk(1, 1, 16'h0105, 0, 0, 0, 16'h0000, 16'h0000, 0));
    applyStimulus(mk(1, 1, 16'h0205, 1, 0, 1, 16'h0205, 16'h0300, 0));
    applyStimulus(mk(1, 1, 16'h0105, 0, 0, 0, 16'h0000, 16'h0000, 0));
    applyStimulus(mk(1, 1, 16'h0205, 0, 0, 0, 16'h0000, 16'h0000, 0));
    applyStimulus(mk(1, 1, 16'hFFFF, 0, 0, 0, 16'h0000, 16'h0000, 0));

    for (int i = 0; i < 3; i++)
      applyStimulus(mk(1, 1, 16'h0010, 0, 0, 0, 16'h0000, 16'h0000, 0));
    applyStimulus(mk(1, 0, 16'h0010, 0, 1, 0, 16'h0030, 16'h0031, 1));
    applyStimulus(mk(1, 0, 16'h0030, 1, 0, 0, 16'h0044, 16'h0000, 0));
    applyStimulus(mk(1, 0, 16'h0030, 0, 0, 0, 16'h0000, 16'h0000, 0));

    // Reset in RUN, then again mid-sweep, must restart the full sweep.
    applyStimulus(mk(0, 1, 16'h0010, 0, 0, 0, 16'h0000, 16'h0000, 0));
    for (int i = 0; i < 5; i++)
      applyStimulus(mk(1, 1, 16'h0010, 0, 1, 0, 16'h0010, 16'h0040, 0));
    applyStimulus(mk(0, 1, 16'h0010, 0, 0, 0, 16'h0000, 16'h0000, 0));
    for (int i = 0; i < ENTRIES + 2; i++)
      applyStimulus(mk(1, 1, 16'h0010, 0, 0, 0, 16'h0000, 16'h0000, 0));

    for (int i = 0; i < 800; i++) begin
      idle = mk(($urandom_range(0, 299) != 0), 1'($urandom), randPc(),
                1'($urandom), ($urandom_range(0, 4) == 0), 1'($urandom),
                randPc(), WS'($urandom), ($urandom_range(0, 5) == 0));
      applyStimulus(idle);
    end

    applyStimulus(mk(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0));
    @(posedge Clk); #1;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: actual=%0d required=0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
